onchip_mem_arbiter: RTL and testbench



---
 rtl/onchip_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// Shares the single-port frame-buffer RAM between the CPU Avalon slave and the LED scan engine.
// Define ONCHIP_ARB_FAIRNESS_EN to bound consecutive scanner wins while the CPU waits.
module onchip_mem_arbiter #(
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned DEPTH          = 64000,
   parameter int unsigned MAX_SCAN_BURST = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     cpu_address,
   input  logic                  cpu_read,
   input  logic                  cpu_write,
   input  logic [DATA_W-1:0]     cpu_writedata,
   input  logic [DATA_W/8-1:0]   cpu_byteenable,
   output logic                  cpu_waitrequest,
   output logic [DATA_W-1:0]     cpu_readdata,
   output logic                  cpu_readdatavalid,
   input  logic                  scan_req,
   input  logic [ADDR_W-1:0]     scan_address,
   output logic                  scan_grant,
   output logic [DATA_W-1:0]     scan_rdata,
   output logic                  scan_rvalid,
   output logic [ADDR_W-1:0]     mem_address,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic [DATA_W-1:0]     mem_writedata,
   input  logic [DATA_W-1:0]     mem_readdata
);

   typedef enum logic {OWN_CPU, OWN_SCAN} owner_e;

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   if (MAX_SCAN_BURST < 1 || MAX_SCAN_BURST > 15) begin : g_bad_burst
      $error("onchip_mem_arbiter: MAX_SCAN_BURST must be 1..15");
   end

   logic                cpu_req;
   logic                cpu_win;
   logic                scan_win;
   logic                grant;
   logic                win_in_range;
   logic [ADDR_W-1:0]   win_addr;
   logic [ADDR_W-1:0]   addr_q;
   logic                rd_valid_q, rd_valid_d;
   logic                rd_oor_q, rd_oor_d;
   owner_e              rd_owner_q, rd_owner_d;
   logic [DATA_W-1:0]   rdata;

   assign cpu_req = cpu_read | cpu_write;

`ifdef ONCHIP_ARB_FAIRNESS_EN
   logic [3:0] starve_q, starve_d;
   logic       force_cpu;

   assign force_cpu = cpu_req & (starve_q == 4'(MAX_SCAN_BURST));
   assign scan_win  = scan_req & ~force_cpu;

   // Counts scanner wins while the CPU is left waiting; any CPU win or idle cycle restarts it.
   always_comb begin
      starve_d = starve_q;
      if (!cpu_req || cpu_win) begin
         starve_d = '0;
      end else if (starve_q != '1) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign scan_win = scan_req;
`endif

   assign cpu_win = cpu_req & ~scan_win;

   always_comb begin
      grant          = scan_win | cpu_win;
      win_addr       = scan_win ? scan_address : cpu_address;
      win_in_range   = {1'b0, win_addr} < DEPTH_L;
      mem_address    = grant ? win_addr : addr_q;
      mem_chipselect = grant & win_in_range;
      mem_write      = cpu_win & cpu_write & win_in_range;
      mem_byteenable = '0;
      if (scan_win) begin
         mem_byteenable = '1;
      end else if (cpu_win) begin
         mem_byteenable = cpu_byteenable;
      end
      mem_writedata   = cpu_win ? cpu_writedata : '0;
      cpu_waitrequest = cpu_req & ~cpu_win;
      scan_grant      = scan_win;
      rd_valid_d      = scan_win | (cpu_win & cpu_read);
      rd_owner_d      = scan_win ? OWN_SCAN : OWN_CPU;
      rd_oor_d        = ~win_in_range;
   end

   // Out-of-range reads never strobe the RAM, so their q is ignored and zero is returned.
   always_comb begin
      rdata             = rd_oor_q ? '0 : mem_readdata;
      cpu_readdata      = rdata;
      scan_rdata        = rdata;
      cpu_readdatavalid = rd_valid_q & (rd_owner_q == OWN_CPU);
      scan_rvalid       = rd_valid_q & (rd_owner_q == OWN_SCAN);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_owner_q <= OWN_CPU;
         rd_oor_q   <= 1'b0;
      end else begin
         addr_q     <= mem_address;
         rd_valid_q <= rd_valid_d;
         rd_owner_q <= rd_owner_d;
         rd_oor_q   <= rd_oor_d;
      end
   end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a shadow-memory reference model.
module tb_onchip_mem_arbiter;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 64000;
   localparam int unsigned MSB    = 4;
`ifdef ONCHIP_ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic                clk;
   logic                reset_n;
   logic [ADDR_W-1:0]   cpu_address;
   logic                cpu_read;
   logic                cpu_write;
   logic [DATA_W-1:0]   cpu_writedata;
   logic [3:0]          cpu_byteenable;
   logic                cpu_waitrequest;
   logic [DATA_W-1:0]   cpu_readdata;
   logic                cpu_readdatavalid;
   logic                scan_req;
   logic [ADDR_W-1:0]   scan_address;
   logic                scan_grant;
   logic [DATA_W-1:0]   scan_rdata;
   logic                scan_rvalid;
   logic [ADDR_W-1:0]   mem_address;
   logic                mem_chipselect;
   logic                mem_write;
   logic [3:0]          mem_byteenable;
   logic [DATA_W-1:0]   mem_writedata;
   logic [DATA_W-1:0]   mem_readdata;

   onchip_mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_SCAN_BURST(MSB)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
      .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
      .cpu_readdatavalid(cpu_readdatavalid),
      .scan_req(scan_req), .scan_address(scan_address), .scan_grant(scan_grant),
      .scan_rdata(scan_rdata), .scan_rvalid(scan_rvalid),
      .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
      .mem_readdata(mem_readdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] init_word(input int unsigned a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   // RAM: registered address, unregistered q.
   logic [31:0] ram [0:DEPTH-1];
   logic [15:0] ram_a;
   assign mem_readdata = ram[ram_a];
   initial begin
      for (int unsigned i = 0; i < DEPTH; i++) ram[i] = init_word(i);
      ram_a = '0;
      forever begin
         @(posedge clk);
         if (mem_chipselect) begin
            if (mem_write)
               for (int b = 0; b < 4; b++)
                  if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            ram_a <= mem_address;
         end
      end
   end

   // Reference model state
   logic [31:0]  shadow [0:DEPTH-1];
   bit           p_valid, p_scan;
   logic [31:0]  p_data;
   logic [15:0]  last_addr;
   int unsigned  starve;
   bit           m_cpu_gnt, m_scan_gnt, obs_cpu_gnt;
   int           n_pass, n_fail, n_total;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] pick();
      if ($urandom_range(0, 4) == 0) return 16'($urandom_range(63990, 65535));
      return 16'($urandom_range(0, 31));
   endfunction

   // One clock cycle: predict from the current inputs, compare mid-cycle, then advance the model.
   task automatic cycle();
      int           w;
      bit           creq, inr;
      logic [15:0]  a;
      logic [31:0]  e_be, e_addr;
      @(negedge clk);
      if (!reset_n) begin
         p_valid   = 1'b0;
         last_addr = '0;
         starve    = 0;
      end
      creq = cpu_read | cpu_write;
      w = 0;
      if (FAIR && creq && starve == MSB) w = 1;
      else if (scan_req)                 w = 2;
      else if (creq)                     w = 1;
      a      = (w == 2) ? scan_address : cpu_address;
      inr    = (32'(a) < DEPTH);
      e_be   = (w == 2) ? 32'hF : (w == 1) ? 32'(cpu_byteenable) : 32'h0;
      e_addr = (w != 0) ? 32'(a) : 32'(last_addr);
      chk("waitrequest", 32'(cpu_waitrequest), 32'(creq && w != 1));
      chk("scan_grant",  32'(scan_grant),      32'(w == 2));
      chk("chipselect",  32'(mem_chipselect),  32'(w != 0 && inr));
      chk("mem_write",   32'(mem_write),       32'(w == 1 && cpu_write && inr));
      chk("mem_address", 32'(mem_address),     e_addr);
      chk("byteenable",  32'(mem_byteenable),  e_be);
      if (w == 1 && cpu_write && inr) chk("writedata", mem_writedata, cpu_writedata);
      chk("cpu_rdvalid", 32'(cpu_readdatavalid), 32'(p_valid && !p_scan));
      chk("scan_rvalid", 32'(scan_rvalid),       32'(p_valid && p_scan));
      if (p_valid && !p_scan) chk("cpu_rdata",  cpu_readdata, p_data);
      if (p_valid &&  p_scan) chk("scan_rdata", scan_rdata,   p_data);
      obs_cpu_gnt = creq && !cpu_waitrequest;
      // advance model
      if (w == 1 && cpu_write && inr)
         for (int b = 0; b < 4; b++)
            if (cpu_byteenable[b]) shadow[a][8*b +: 8] = cpu_writedata[8*b +: 8];
      p_valid   = (w == 2) || (w == 1 && cpu_read);
      p_scan    = (w == 2);
      p_data    = inr ? shadow[a] : 32'h0;
      last_addr = e_addr[15:0];
      if (!creq || w == 1) starve = 0;
      else if (starve < 15) starve++;
      m_cpu_gnt  = (w == 1);
      m_scan_gnt = (w == 2);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cpu_read = 1'b0; cpu_write = 1'b0; scan_req = 1'b0;
   endtask

   initial begin
      logic [9:0] pat;
      int r;
      n_pass = 0; n_fail = 0; n_total = 0;
      for (int unsigned i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
      p_valid = 1'b0; p_scan = 1'b0; p_data = '0; last_addr = '0; starve = 0;
      m_cpu_gnt = 1'b0; m_scan_gnt = 1'b0; obs_cpu_gnt = 1'b0;
      reset_n = 1'b0;
      cpu_address = '0; cpu_writedata = '0; cpu_byteenable = '0;
      scan_address = '0;
      idle();
      @(posedge clk); #1;
      cycle();
      chk("rst_addr", 32'(mem_address), 32'h0);

      // Partial write right at reset release, then read back with the scanner idle
      reset_n = 1'b1;
      cpu_write = 1'b1; cpu_address = 16'h0010; cpu_writedata = 32'hA5A5_1234; cpu_byteenable = 4'b0011;
      cycle();
      cpu_write = 1'b0; cpu_read = 1'b1;
      cycle();
      idle();
      chk("t1_rdvalid", 32'(cpu_readdatavalid), 32'h1);
      chk("t1_lo", 32'(cpu_readdata[15:0]), 32'h1234);
      chk("t1_hi", 32'(cpu_readdata[31:16]), 32'(init_word(16) >> 16));
      cycle();

      // Scanner back-to-back reads
      for (int i = 0; i < 4; i++) begin
         scan_req = 1'b1; scan_address = 16'(i);
         cycle();
      end
      idle();
      cycle();

      // CPU read pending under continuous scanner traffic
      cpu_read = 1'b1; cpu_address = 16'h0010;
      pat = '0;
      for (int i = 0; i < 10; i++) begin
         scan_req = 1'b1; scan_address = 16'(i + 4);
         cycle();
         pat[i] = obs_cpu_gnt;
      end
      chk("starve_pattern", 32'(pat), FAIR ? 32'h210 : 32'h0);
      scan_req = 1'b0;
      cycle();
      idle();
      cycle();

      // Out-of-range write/read at exactly DEPTH
      cpu_write = 1'b1; cpu_address = 16'hFA00; cpu_writedata = 32'hFFFF_FFFF; cpu_byteenable = 4'hF;
      cycle();
      cpu_write = 1'b0; cpu_read = 1'b1;
      cycle();
      idle();
      chk("oor_rdvalid", 32'(cpu_readdatavalid), 32'h1);
      chk("oor_rdata", cpu_readdata, 32'h0);
      cycle();

      // Last implemented word: CPU write, scanner read
      cpu_write = 1'b1; cpu_address = 16'hF9FF; cpu_writedata = 32'h1357_9BDF; cpu_byteenable = 4'hF;
      cycle();
      cpu_write = 1'b0; scan_req = 1'b1; scan_address = 16'hF9FF;
      cycle();
      idle();
      chk("last_word", scan_rdata, 32'h1357_9BDF);
      cycle();

      // Randomized traffic; requesters hold until granted
      for (int i = 0; i < 400; i++) begin
         if (!(cpu_read || cpu_write) || m_cpu_gnt) begin
            r = int'($urandom_range(0, 3));
            cpu_read       = (r == 1 || r == 3);
            cpu_write      = (r == 2);
            cpu_address    = pick();
            cpu_writedata  = $urandom;
            cpu_byteenable = 4'($urandom_range(0, 15));
         end
         if (!scan_req || m_scan_gnt) begin
            scan_req     = ($urandom_range(0, 3) != 0);
            scan_address = pick();
         end
         cycle();
      end
      idle();
      cycle();

      // Reset asserted while a scanner read is in flight
      scan_req = 1'b1; scan_address = 16'h0002;
      cycle();
      idle();
      reset_n = 1'b0;
      #1;
      chk("rst_scan_rvalid", 32'(scan_rvalid), 32'h0);
      chk("rst_cpu_rdvalid", 32'(cpu_readdatavalid), 32'h0);
      cycle();
      cycle();
      reset_n = 1'b1;
      cycle();
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
